decoder_38_pulse: RTL

- Registered 3-to-8 decoder with handshake.
- Accepts a 3-bit code and drives the matching one-hot line of an 8-bit output for a programmable number of cycles.
- Then enforces an optional idle gap before accepting the next code.
- It is the consumer-side counterpart of the 8-to-3 priority encoder: encoder codes are turned back into timed one-hot strobes (LED/select lines, channel enables).

---
 rtl/decoder_pkg.sv | 21 ++
 rtl/decoder_38_core.sv | 14 +
 rtl/decoder_38_pulse.sv | 97 +++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared types and constants for the timed 3-to-8 pulse decoder.
// Defining DECODER_38_ACTIVE_LOW_EN makes the decoded output idle high (74x138 style).
package decoder_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Idle/reset level of out; a pulse is this value with the selected bit flipped.
`ifdef DECODER_38_ACTIVE_LOW_EN
    localparam logic [ONEHOT_W-1:0] OUT_IDLE = 8'hFF;
`else
    localparam logic [ONEHOT_W-1:0] OUT_IDLE = 8'h00;
`endif

endpackage

// File: rtl/decoder_38_core.sv
// Combinational 3-bit binary to 8-bit one-hot decoder.
module decoder_38_core
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0]   code,
    output logic [ONEHOT_W-1:0] onehot
);

    always_comb begin
        onehot       = '0;
        onehot[code] = 1'b1;
    end

endmodule

// File: rtl/decoder_38_pulse.sv
// Registered 3-to-8 decoder: drives a one-hot strobe for PULSE_LEN cycles per accepted code,
// then holds off for GAP_LEN cycles. Output polarity follows DECODER_38_ACTIVE_LOW_EN.
module decoder_38_pulse
    import decoder_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in_code,
    output logic [ONEHOT_W-1:0] out,
    output logic                out_active,
    output logic                busy
);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;
    logic [ONEHOT_W-1:0] onehot;
    logic                accept;

    // Decode the code being latched so out can be registered in the same edge.
    always_comb begin
        accept = (state == ST_IDLE) && in_valid && in_ready;
        code_d = accept ? in_code : code_q;
    end

    decoder_38_core u_core (
        .code   (code_d),
        .onehot (onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            code_q     <= '0;
            out        <= OUT_IDLE;
            out_active <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            code_q <= code_d;
            unique case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        state      <= ST_ACTIVE;
                        cnt        <= CNT_W'(PULSE_LEN - 1);
                        out        <= OUT_IDLE ^ onehot;
                        out_active <= 1'b1;
                        busy       <= 1'b1;
                        in_ready   <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt == '0) begin
                        out        <= OUT_IDLE;
                        out_active <= 1'b0;
                        if (GAP_LEN > 0) begin
                            state <= ST_GAP;
                            cnt   <= CNT_W'(GAP_LEN - 1);
                        end else begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    out        <= OUT_IDLE;
                    out_active <= 1'b0;
                    busy       <= 1'b0;
                    in_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule
